// File: rtl/uart_v2_pkg.sv
// Shared constants and state types for the uart_v2 block.
package uart_v2_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO, 2**W words of B bits.
// A read and a write in the same cycle both succeed, even when full.
module uart_sync_fifo #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full
);

  logic [B-1:0] mem [2**W];
  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic [W:0]   count;
  logic         do_rd;
  logic         do_wr;

  assign do_rd  = rd & ~empty;
  assign do_wr  = wr & (~full | do_rd);
  assign empty  = (count == '0);
  assign full   = count[W];
  assign r_data = mem[r_ptr];

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[w_ptr] <= w_data;
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) w_ptr <= w_ptr + 1'b1;
      if (do_rd) r_ptr <= r_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_v2.sv
// uart_v2: full-duplex UART with runtime baud divisor, optional parity and
// sticky line-error flags. RX and TX are each buffered by a FWFT FIFO.
module uart_v2
  import uart_v2_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY     = PARITY_NONE,
  parameter int DVSR_WIDTH = 11,
  parameter int FIFO_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  wr_uart,
  input  logic [DBIT-1:0]       wr_data,
  input  logic                  rd_uart,
  output logic [DBIT-1:0]       rd_data,
  output logic                  rx_empty,
  output logic                  tx_full,
  output logic                  tx_idle,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  input  logic                  clr_err,
  input  logic                  rx,
  output logic                  tx
);

  localparam logic [4:0] SB_LAST  = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST = 3'(DBIT - 1);
  localparam logic       PAR_EN   = (PARITY == PARITY_EVEN) || (PARITY == PARITY_ODD);
  localparam logic       PAR_INV  = (PARITY == PARITY_ODD);

  logic [DVSR_WIDTH-1:0] baud_cnt;
  logic                  s_tick;
  logic [2:0]            rx_sync;
  logic                  rx_s;
  logic                  rx_fall;

  rx_state_t             rx_state, rx_state_n;
  logic [4:0]            rx_cnt, rx_cnt_n;
  logic [2:0]            rx_n, rx_n_n;
  logic [DBIT-1:0]       rx_b, rx_b_n;
  logic                  rx_par, rx_par_n;
  logic                  rx_push, rx_full;
  logic                  set_frame, set_par, set_ovr;

  tx_state_t             tx_state, tx_state_n;
  logic [4:0]            tx_cnt, tx_cnt_n;
  logic [2:0]            tx_n, tx_n_n;
  logic [DBIT-1:0]       tx_b, tx_b_n;
  logic                  tx_par, tx_par_n;
  logic                  tx_load, tx_pop, tx_empty, tx_next;
  logic [DBIT-1:0]       tx_head;

  assign s_tick  = (dvsr != '0) && (baud_cnt == dvsr - 1'b1);
  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_sync[2] & ~rx_sync[1];
  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  // Baud counter; >= guards against the divisor shrinking below the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) baud_cnt <= '0;
    else if (dvsr == '0 || baud_cnt >= dvsr - 1'b1) baud_cnt <= '0;
    else baud_cnt <= baud_cnt + 1'b1;
  end

  // Two-flop synchroniser plus one extra stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_sync <= '1;
    else rx_sync <= {rx_sync[1:0], rx};
  end

  // RX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_n     <= rx_n_n;
      rx_b     <= rx_b_n;
      rx_par   <= rx_par_n;
    end
  end

  // RX next state: mid-bit sampling, stop check, push and error decisions.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_n_n     = rx_n;
    rx_b_n     = rx_b;
    rx_par_n   = rx_par;
    rx_push    = 1'b0;
    set_frame  = 1'b0;
    set_par    = 1'b0;
    set_ovr    = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_state_n = RX_START;
        rx_cnt_n   = '0;
      end
      RX_START: if (s_tick) begin
        if (rx_cnt == 5'd7) begin
          rx_cnt_n   = '0;
          rx_n_n     = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_DATA: if (s_tick) begin
        if (rx_cnt == 5'd15) begin
          rx_cnt_n = '0;
          rx_b_n   = {rx_s, rx_b[DBIT-1:1]};
          if (rx_n == BIT_LAST) rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
          else rx_n_n = rx_n + 1'b1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_PARITY: if (s_tick) begin
        if (rx_cnt == 5'd15) begin
          rx_cnt_n   = '0;
          rx_par_n   = rx_s;
          rx_state_n = RX_STOP;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      RX_STOP: if (s_tick) begin
        if (rx_cnt == SB_LAST) begin
          rx_state_n = RX_IDLE;
          if (!rx_s) set_frame = 1'b1;
          else begin
            set_par = PAR_EN && (rx_par != ((^rx_b) ^ PAR_INV));
            // A same-cycle host read frees a slot, so that push is not an overrun.
            if (rx_full && !rd_uart) set_ovr = 1'b1;
            else rx_push = 1'b1;
          end
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // TX state register; tx is registered so the pin never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_n     <= tx_n_n;
      tx_b     <= tx_b_n;
      tx_par   <= tx_par_n;
      tx       <= tx_next;
    end
  end

  // TX next state. Words launch on a baud tick so the start bit is exactly
  // 16 ticks; a queued word follows the stop bit without passing through IDLE.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_n_n     = tx_n;
    tx_b_n     = tx_b;
    tx_par_n   = tx_par;
    tx_load    = 1'b0;
    case (tx_state)
      TX_IDLE: if (s_tick && !tx_empty) tx_load = 1'b1;
      TX_START: if (s_tick) begin
        if (tx_cnt == 5'd15) begin
          tx_cnt_n   = '0;
          tx_n_n     = '0;
          tx_state_n = TX_DATA;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_DATA: if (s_tick) begin
        if (tx_cnt == 5'd15) begin
          tx_cnt_n = '0;
          tx_b_n   = {1'b0, tx_b[DBIT-1:1]};
          if (tx_n == BIT_LAST) tx_state_n = PAR_EN ? TX_PARITY : TX_STOP;
          else tx_n_n = tx_n + 1'b1;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_PARITY: if (s_tick) begin
        if (tx_cnt == 5'd15) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      TX_STOP: if (s_tick) begin
        if (tx_cnt == SB_LAST) begin
          if (!tx_empty) tx_load = 1'b1;
          else tx_state_n = TX_IDLE;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_b_n     = tx_head;
      tx_par_n   = (^tx_head) ^ PAR_INV;
      tx_cnt_n   = '0;
      tx_state_n = TX_START;
    end
    tx_pop = tx_load;
    case (tx_state_n)
      TX_START:  tx_next = 1'b0;
      TX_DATA:   tx_next = tx_b_n[0];
      TX_PARITY: tx_next = tx_par_n;
      default:   tx_next = 1'b1;
    endcase
  end

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (set_frame) frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (set_par) parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (set_ovr) overrun_err <= 1'b1;
      else if (clr_err) overrun_err <= 1'b0;
    end
  end

  uart_sync_fifo #(.B(DBIT), .W(FIFO_W)) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .rd     (rd_uart),
    .wr     (rx_push),
    .w_data (rx_b),
    .r_data (rd_data),
    .empty  (rx_empty),
    .full   (rx_full)
  );

  uart_sync_fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
    .clk    (clk),
    .rst    (rst),
    .rd     (tx_pop),
    .wr     (wr_uart),
    .w_data (wr_data),
    .r_data (tx_head),
    .empty  (tx_empty),
    .full   (tx_full)
  );

endmodule

// File: tb/tb_uart_v2.sv
// Bench for uart_v2: line-level model of frames and of the RX FIFO/flags.
`timescale 1ns/1ps
module tb_uart_v2;
  import uart_v2_pkg::*;

  localparam int NB    = 11;  // start + 8 data + parity + stop
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] dvsr = 11'd54;
  always #5 clk = ~clk;

  // main instance: 8 data bits, even parity
  logic       wr_uart = 1'b0, rd_uart = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       rx_empty, tx_full, tx_idle, frame_err, parity_err, overrun_err;
  logic       rx, tx;
  logic       rx_drv = 1'b1, loopback = 1'b0;
  assign rx = loopback ? tx : rx_drv;

  // second instance: 8 data bits, no parity, looped back on itself
  logic       wr_uart_0 = 1'b0, rd_uart_0 = 1'b0;
  logic [7:0] wr_data_0 = 8'h00;
  logic [7:0] rd_data_0;
  logic       rx_empty_0, tx_full_0, tx_idle_0, frame_err_0, parity_err_0, overrun_err_0;
  logic       tx_0;

  uart_v2 #(.DBIT(8), .SB_TICK(16), .PARITY(PARITY_EVEN), .DVSR_WIDTH(11), .FIFO_W(4)) dut (
    .clk(clk), .rst(rst), .dvsr(dvsr), .wr_uart(wr_uart), .wr_data(wr_data),
    .rd_uart(rd_uart), .rd_data(rd_data), .rx_empty(rx_empty), .tx_full(tx_full),
    .tx_idle(tx_idle), .frame_err(frame_err), .parity_err(parity_err),
    .overrun_err(overrun_err), .clr_err(clr_err), .rx(rx), .tx(tx));

  uart_v2 #(.DBIT(8), .SB_TICK(16), .PARITY(PARITY_NONE), .DVSR_WIDTH(11), .FIFO_W(4)) dut0 (
    .clk(clk), .rst(rst), .dvsr(dvsr), .wr_uart(wr_uart_0), .wr_data(wr_data_0),
    .rd_uart(rd_uart_0), .rd_data(rd_data_0), .rx_empty(rx_empty_0), .tx_full(tx_full_0),
    .tx_idle(tx_idle_0), .frame_err(frame_err_0), .parity_err(parity_err_0),
    .overrun_err(overrun_err_0), .clr_err(1'b0), .rx(tx_0), .tx(tx_0));

  int tests = 0;
  int fails = 0;

  // model state
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  bit exp_frame = 0, exp_par = 0, exp_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame as it must appear on the line: index 0 is sent first.
  function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
    logic [NB-1:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    f[9]  = (ones % 2) == 1;
    f[10] = 1'b1;
    return f;
  endfunction

  // What the receiver must do with a frame that just finished on its line.
  function automatic void rx_model(input logic [7:0] d, input bit par_ok, input bit stop);
    if (!stop) exp_frame = 1;
    else begin
      if (!par_ok) exp_par = 1;
      if (rx_exp_q.size() == DEPTH) exp_ovr = 1;
      else rx_exp_q.push_back(d);
    end
  endfunction

  // Compare process: checks every bit of every frame on tx at mid-bit.
  bit            mon_busy = 0;
  bit            prev_tx = 1;
  int            mon_cnt = 0;
  int            mon_bt;
  int            mon_idx;
  logic [NB-1:0] mon_frame = '1;
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 0;
      prev_tx  = 1;
      tx_exp_q.delete();
    end else begin
      mon_bt = 16 * int'(dvsr);
      if (mon_busy) begin
        mon_cnt++;
        if (mon_bt != 0 && (mon_cnt % mon_bt) == mon_bt / 2) begin
          mon_idx = mon_cnt / mon_bt;
          check("tx_bit", tx, mon_frame[mon_idx]);
          if (mon_idx == NB - 1) begin
            mon_busy = 0;
            if (loopback) rx_model(mon_frame[8:1], 1, 1);
          end
        end
      end else if (prev_tx && !tx) begin
        if (tx_exp_q.size() == 0) check("tx_unexpected_start", tx_exp_q.size(), 1);
        else begin
          mon_frame = frame_bits(tx_exp_q.pop_front());
          mon_busy  = 1;
          mon_cnt   = 0;
        end
      end
      prev_tx = tx;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_data = d;
    wr_uart = 1'b1;
    step();
    wr_uart = 1'b0;
    if (tx_exp_q.size() < DEPTH) tx_exp_q.push_back(d);
  endtask

  task automatic read_word(input string name);
    if (rx_exp_q.size() == 0) check({name, "_empty"}, rx_empty, 1);
    else begin
      check({name, "_empty"}, rx_empty, 0);
      check(name, rd_data, rx_exp_q.pop_front());
      rd_uart = 1'b1;
      step();
      rd_uart = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    logic [NB-1:0] f;
    int bt;
    f = frame_bits(d);
    f[9]  = f[9] ^ bad_par;
    f[10] = stop;
    bt = 16 * int'(dvsr);
    for (int i = 0; i < NB; i++) begin
      rx_drv = f[i];
      step(bt);
    end
    rx_drv = 1'b1;
    step(bt);
    rx_model(d, !bad_par, stop);
  endtask

  task automatic check_flags(input string name);
    check({name, "_frame_err"}, frame_err, exp_frame);
    check({name, "_parity_err"}, parity_err, exp_par);
    check({name, "_overrun_err"}, overrun_err, exp_ovr);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    exp_frame = 0;
    exp_par   = 0;
    exp_ovr   = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(tx_idle && tx_exp_q.size() == 0 && !mon_busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_idle_timeout"}, n < budget, 1);
    step(16 * int'(dvsr));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [9:0] a5_bits;
    a5_bits = 10'b1101001010;

    // reset state
    step(4);
    check("rst_tx", tx, 1);
    check("rst_rx_empty", rx_empty, 1);
    rst = 1'b0;
    step(2);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_idle", tx_idle, 1);
    check_flags("rst");
    check("rst_tx_0", tx_0, 1);
    check("rst_rx_empty_0", rx_empty_0, 1);
    check("rst_tx_full_0", tx_full_0, 0);
    check("rst_tx_idle_0", tx_idle_0, 1);
    check("rst_flags_0", {frame_err_0, parity_err_0, overrun_err_0}, 0);

    // 1: no-parity frame of 0xA5 at dvsr=54, 864 clocks per bit
    wr_data_0 = 8'hA5;
    wr_uart_0 = 1'b1;
    step();
    wr_uart_0 = 1'b0;
    n = 0;
    while (tx_0 && n < 200) begin step(); n++; end
    check("t1_start_seen", tx_0, 0);
    n = 0;
    while (!tx_0 && n < 2000) begin step(); n++; end
    check("t1_start_len", n, 864);
    step(432);
    check("t1_bit1", tx_0, a5_bits[1]);
    for (int i = 2; i < 10; i++) begin
      step(864);
      check($sformatf("t1_bit%0d", i), tx_0, a5_bits[i]);
    end
    n = 0;
    while (!tx_idle_0 && n < 2000) begin step(); n++; end
    check("t1_tx_idle", tx_idle_0, 1);
    step(20);
    check("t1_rx_empty_0", rx_empty_0, 0);
    check("t1_rd_data_0", rd_data_0, 8'hA5);

    // 2: even-parity loopback of three words
    dvsr = 11'd2;
    loopback = 1'b1;
    step(40);
    write_word(8'h00);
    write_word(8'hFF);
    write_word(8'h3C);
    wait_idle("t2", 3000);
    check("t2_lit0", rd_data, 8'h00);
    read_word("t2_r0");
    check("t2_lit1", rd_data, 8'hFF);
    read_word("t2_r1");
    check("t2_lit2", rd_data, 8'h3C);
    read_word("t2_r2");
    check_flags("t2");

    // 3: wrong parity bit still delivers the word
    loopback = 1'b0;
    step(40);
    send_frame(8'h5A, 1, 1);
    check("t3_par_lit", parity_err, 1);
    check_flags("t3");
    check("t3_data_lit", rd_data, 8'h5A);
    read_word("t3_r");
    clear_errs();
    check("t3_clr", parity_err, 0);

    // 4: stop bit low, then a short glitch
    send_frame(8'h81, 0, 0);
    check("t4_frame_lit", frame_err, 1);
    check("t4_empty", rx_empty, 1);
    check_flags("t4");
    clear_errs();
    rx_drv = 1'b0;
    step(4);
    rx_drv = 1'b1;
    step(96);
    check("t4_glitch_empty", rx_empty, 1);
    check_flags("t4_glitch");

    // 5: fill TX with ticks stopped, then overflow the RX FIFO via loopback
    loopback = 1'b1;
    dvsr = 11'd0;
    step(5);
    for (int i = 0; i < 17; i++) write_word(8'(i * 13 + 1));
    check("t5_tx_full", tx_full, 1);
    check("t5_tx_idle", tx_idle, 0);
    dvsr = 11'd2;
    wait_idle("t5a", 8000);
    check("t5_no_ovr_yet", overrun_err, 0);
    write_word(8'hEE);
    wait_idle("t5b", 1000);
    check("t5_ovr_lit", overrun_err, 1);
    check_flags("t5");
    for (int i = 0; i < 16; i++) read_word($sformatf("t5_r%0d", i));
    check("t5_empty_lit", rx_empty, 1);

    // 6: reset mid-frame forces tx high at once, then a clean frame
    loopback = 1'b0;
    clear_errs();
    step(40);
    write_word(8'h33);
    n = 0;
    while (tx && n < 200) begin step(); n++; end
    step(3 * 32 + 16);
    check("t6_mid_low", tx, 0);
    rst = 1'b1;
    #1;
    check("t6_tx_async", tx, 1);
    step(3);
    rst = 1'b0;
    rx_exp_q.delete();
    step(3);
    check_flags("t6_rst");
    write_word(8'h55);
    wait_idle("t6", 1000);
    check("t6_tx_final", tx, 1);
    check("t6_rx_empty", rx_empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
